// File: rtl/q_slot_ctrl.sv
// Q-algorithm slot-counter sequencer: decodes inventory commands, tracks Q,
// strobes the RNG slot counter and seeds the RNG from ROM after reset.
module q_slot_ctrl #(
  parameter logic [3:0] Q_RESET       = 4'd0,
  parameter bit         SEED_ON_RESET = 1'b1,
  parameter int         SEED_TIMEOUT  = 255
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_cmd_valid,
  input  logic [1:0] i_cmd_type,
  input  logic [3:0] i_q_query,
  input  logic [2:0] i_updn,
  input  logic       i_slotz_rng,
  input  logic       i_rom_valid,
  output logic       o_rom_req,
  output logic       o_seed_in_rng,
  output logic [3:0] o_q_dec,
  output logic       o_newSlot_cu,
  output logic       o_decSlot_cu,
  output logic       o_cmd_ready,
  output logic       o_reply_en,
  output logic       o_in_arb
);

  typedef enum logic [2:0] {
    S_SEED_REQ,
    S_READY,
    S_LOAD,
    S_DEC,
    S_EVAL,
    S_ARB,
    S_REPLY
  } state_e;

  localparam logic [1:0] CMD_QUERY  = 2'b00;
  localparam logic [1:0] CMD_QADJ   = 2'b01;
  localparam logic [1:0] CMD_QREP   = 2'b10;
  localparam logic [1:0] CMD_ABORT  = 2'b11;
  localparam logic [2:0] UPDN_INC   = 3'b110;
  localparam logic [2:0] UPDN_KEEP  = 3'b000;
  localparam logic [2:0] UPDN_DEC   = 3'b011;

  localparam int CNT_W = (SEED_TIMEOUT < 2) ? 1 : $clog2(SEED_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(SEED_TIMEOUT - 1);
  localparam state_e RESET_STATE = SEED_ON_RESET ? S_SEED_REQ : S_READY;

  state_e           state_q, state_d;
  logic [3:0]       q_q, q_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             rom_req_q, rom_req_d;
  logic             seed_q, seed_d;
  logic             new_slot_q, new_slot_d;
  logic             dec_slot_q, dec_slot_d;
  logic             cmd_ready_q, cmd_ready_d;
  logic             reply_q, reply_d;
  logic             in_arb_q, in_arb_d;
  logic             accept;

  assign accept = i_cmd_valid && cmd_ready_q;

  always_comb begin
    state_d = state_q;
    q_d     = q_q;
    cnt_d   = cnt_q;
    seed_d  = 1'b0;
    reply_d = 1'b0;

    unique case (state_q)
      S_SEED_REQ: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (i_rom_valid) begin
          seed_d  = 1'b1;
          state_d = S_READY;
        end else if (cnt_q == TIMEOUT_LAST) begin
          state_d = S_READY;
        end
      end
      S_LOAD, S_DEC: state_d = S_EVAL;
      S_EVAL: begin
        if (i_slotz_rng) begin
          state_d = S_REPLY;
          reply_d = 1'b1;
        end else begin
          state_d = S_ARB;
        end
      end
      S_READY, S_ARB, S_REPLY: begin
        if (accept) begin
          unique case (i_cmd_type)
            CMD_QUERY: begin
              q_d     = i_q_query;
              state_d = S_LOAD;
            end
            CMD_QADJ: begin
              // Unknown updn codes drop the whole command, not just the Q change.
              if (state_q != S_READY) begin
                case (i_updn)
                  UPDN_INC: begin
                    q_d     = (q_q == 4'd15) ? q_q : q_q + 4'd1;
                    state_d = S_LOAD;
                  end
                  UPDN_DEC: begin
                    q_d     = (q_q == 4'd0) ? q_q : q_q - 4'd1;
                    state_d = S_LOAD;
                  end
                  UPDN_KEEP: state_d = S_LOAD;
                  default: ;
                endcase
              end
            end
            CMD_QREP: begin
              if (state_q != S_READY) state_d = S_DEC;
            end
            CMD_ABORT: state_d = S_READY;
            default: ;
          endcase
        end
      end
      default: state_d = S_READY;
    endcase

    // Level outputs are registered copies of the state being entered.
    rom_req_d   = (state_d == S_SEED_REQ);
    new_slot_d  = (state_d == S_LOAD);
    dec_slot_d  = (state_d == S_DEC);
    in_arb_d    = (state_d == S_ARB);
    cmd_ready_d = (state_d == S_READY) || (state_d == S_ARB) || (state_d == S_REPLY);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= RESET_STATE;
      q_q         <= Q_RESET;
      cnt_q       <= '0;
      rom_req_q   <= 1'b0;
      seed_q      <= 1'b0;
      new_slot_q  <= 1'b0;
      dec_slot_q  <= 1'b0;
      cmd_ready_q <= 1'b0;
      reply_q     <= 1'b0;
      in_arb_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      q_q         <= q_d;
      cnt_q       <= cnt_d;
      rom_req_q   <= rom_req_d;
      seed_q      <= seed_d;
      new_slot_q  <= new_slot_d;
      dec_slot_q  <= dec_slot_d;
      cmd_ready_q <= cmd_ready_d;
      reply_q     <= reply_d;
      in_arb_q    <= in_arb_d;
    end
  end

  assign o_rom_req     = rom_req_q;
  assign o_seed_in_rng = seed_q;
  assign o_q_dec       = q_q;
  assign o_newSlot_cu  = new_slot_q;
  assign o_decSlot_cu  = dec_slot_q;
  assign o_cmd_ready   = cmd_ready_q;
  assign o_reply_en    = reply_q;
  assign o_in_arb      = in_arb_q;

endmodule
